// File: rtl/l2tlb_fa_if.sv
// Handshake bundle between the L2 TLB and its L1TLB, directory and flush/perf neighbours.
// The slave view belongs to the TLB; the master view is whoever surrounds it.
interface l2tlb_fa_if #(
   parameter int VPN_W  = 27,
   parameter int PPN_W  = 28,
   parameter int RID_W  = 3,
   parameter int L2ID_W = 6,
   parameter int CNT_W  = 16
);
   logic              l1tlbtol2tlb_req_valid;
   logic              l1tlbtol2tlb_req_retry;
   logic [RID_W-1:0]  l1tlbtol2tlb_req_rid;
   logic [VPN_W-1:0]  l1tlbtol2tlb_req_vpn;

   logic              l2tlbtol1tlb_ack_valid;
   logic              l2tlbtol1tlb_ack_retry;
   logic [RID_W-1:0]  l2tlbtol1tlb_ack_rid;
   logic [PPN_W-1:0]  l2tlbtol1tlb_ack_ppn;
   logic              l2tlbtol1tlb_ack_fault;

   logic              l2todr_req_valid;
   logic              l2todr_req_retry;
   logic [L2ID_W-1:0] l2todr_req_l2id;
   logic [VPN_W-1:0]  l2todr_req_vpn;

   logic              drtol2_snack_valid;
   logic              drtol2_snack_retry;
   logic [L2ID_W-1:0] drtol2_snack_l2id;
   logic [PPN_W-1:0]  drtol2_snack_ppn;
   logic              drtol2_snack_fault;

   logic              flush_valid;
   logic              flush_retry;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   modport slave (
      input  l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req_rid, l1tlbtol2tlb_req_vpn,
      output l1tlbtol2tlb_req_retry,
      output l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_ack_rid, l2tlbtol1tlb_ack_ppn,
      output l2tlbtol1tlb_ack_fault,
      input  l2tlbtol1tlb_ack_retry,
      output l2todr_req_valid, l2todr_req_l2id, l2todr_req_vpn,
      input  l2todr_req_retry,
      input  drtol2_snack_valid, drtol2_snack_l2id, drtol2_snack_ppn, drtol2_snack_fault,
      output drtol2_snack_retry,
      input  flush_valid,
      output flush_retry, hit_count, miss_count
   );

   modport master (
      output l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req_rid, l1tlbtol2tlb_req_vpn,
      input  l1tlbtol2tlb_req_retry,
      input  l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_ack_rid, l2tlbtol1tlb_ack_ppn,
      input  l2tlbtol1tlb_ack_fault,
      output l2tlbtol1tlb_ack_retry,
      input  l2todr_req_valid, l2todr_req_l2id, l2todr_req_vpn,
      output l2todr_req_retry,
      output drtol2_snack_valid, drtol2_snack_l2id, drtol2_snack_ppn, drtol2_snack_fault,
      input  drtol2_snack_retry,
      output flush_valid,
      input  flush_retry, hit_count, miss_count
   );
endinterface

// File: rtl/l2tlb_fa.sv
// Fully-associative L2 TLB: one lookup in flight, misses walk via the directory and are installed.
// Ack and fill-request valids are registered a cycle behind the state that raises them.
module l2tlb_fa #(
   parameter int ENTRIES = 8,
   parameter int VPN_W   = 27,
   parameter int PPN_W   = 28,
   parameter int RID_W   = 3,
   parameter int L2ID_W  = 6,
   parameter int CNT_W   = 16
) (
   input  logic       clk,
   input  logic       reset,
   l2tlb_fa_if.slave  bus
);
   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, ACK} state_e;

   state_e                         state_q, state_d;
   logic [RID_W-1:0]               rid_q, rid_d;
   logic [VPN_W-1:0]               vpn_q, vpn_d;
   logic [PPN_W-1:0]               ppn_q, ppn_d;
   logic                           fault_q, fault_d;
   logic                           ack_valid_q, ack_valid_d;
   logic                           fill_valid_q, fill_valid_d;
   logic [L2ID_W-1:0]              l2id_q, l2id_d;
   logic [L2ID_W-1:0]              out_id_q, out_id_d;
   logic [IDX_W-1:0]               rptr_q, rptr_d;
   logic [CNT_W-1:0]               hit_q, hit_d;
   logic [CNT_W-1:0]               miss_q, miss_d;
   logic [ENTRIES-1:0]             ev_q, ev_d;
   logic [ENTRIES-1:0][VPN_W-1:0]  evpn_q, evpn_d;
   logic [ENTRIES-1:0][PPN_W-1:0]  eppn_q, eppn_d;

   logic [ENTRIES-1:0]             match;
   logic [PPN_W-1:0]               hit_ppn;
   logic                           free_found;
   logic [IDX_W-1:0]               free_idx;
   logic [IDX_W-1:0]               ins_idx;

   for (genvar i = 0; i < ENTRIES; i++) begin : g_cmp
      assign match[i] = ev_q[i] && (evpn_q[i] == vpn_q);
   end

   // No duplicate vpn is ever installed, so OR-ing matching ppns is a clean mux.
   always_comb begin
      hit_ppn = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (match[i]) hit_ppn = hit_ppn | eppn_q[i];
   end

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!ev_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
   end

   assign ins_idx = free_found ? free_idx : rptr_q;

   always_comb begin
      bus.l1tlbtol2tlb_req_retry = 1'b1;
      bus.flush_retry            = 1'b1;
      if (state_q == IDLE) begin
         bus.l1tlbtol2tlb_req_retry = bus.flush_valid;
         bus.flush_retry            = 1'b0;
      end
   end

   assign bus.drtol2_snack_retry     = (state_q != FILL_WAIT);
   assign bus.l2tlbtol1tlb_ack_valid = ack_valid_q;
   assign bus.l2tlbtol1tlb_ack_rid   = rid_q;
   assign bus.l2tlbtol1tlb_ack_ppn   = ppn_q;
   assign bus.l2tlbtol1tlb_ack_fault = fault_q;
   assign bus.l2todr_req_valid       = fill_valid_q;
   assign bus.l2todr_req_l2id        = fill_valid_q ? l2id_q : '0;
   assign bus.l2todr_req_vpn         = fill_valid_q ? vpn_q  : '0;
   assign bus.hit_count              = hit_q;
   assign bus.miss_count             = miss_q;

   always_comb begin
      state_d      = state_q;
      rid_d        = rid_q;
      vpn_d        = vpn_q;
      ppn_d        = ppn_q;
      fault_d      = fault_q;
      ack_valid_d  = 1'b0;
      fill_valid_d = 1'b0;
      l2id_d       = l2id_q;
      out_id_d     = out_id_q;
      rptr_d       = rptr_q;
      hit_d        = hit_q;
      miss_d       = miss_q;
      ev_d         = ev_q;
      evpn_d       = evpn_q;
      eppn_d       = eppn_q;
      unique case (state_q)
         IDLE: begin
            if (bus.flush_valid) begin
               ev_d = '0;
            end else if (bus.l1tlbtol2tlb_req_valid) begin
               rid_d   = bus.l1tlbtol2tlb_req_rid;
               vpn_d   = bus.l1tlbtol2tlb_req_vpn;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (|match) begin
               ppn_d   = hit_ppn;
               fault_d = 1'b0;
               if (hit_q != '1) hit_d = hit_q + 1'b1;
               state_d = ACK;
            end else begin
               if (miss_q != '1) miss_d = miss_q + 1'b1;
               state_d = FILL_REQ;
            end
         end
         FILL_REQ: begin
            if (fill_valid_q && !bus.l2todr_req_retry) begin
               out_id_d = l2id_q;
               // id 0 is never issued, so the counter skips it on wrap
               l2id_d   = (l2id_q == '1) ? L2ID_W'(1) : l2id_q + 1'b1;
               state_d  = FILL_WAIT;
            end else begin
               fill_valid_d = 1'b1;
            end
         end
         FILL_WAIT: begin
            if (bus.drtol2_snack_valid && (bus.drtol2_snack_l2id == out_id_q)) begin
               if (bus.drtol2_snack_fault) begin
                  ppn_d   = '0;
                  fault_d = 1'b1;
               end else begin
                  ppn_d            = bus.drtol2_snack_ppn;
                  fault_d          = 1'b0;
                  ev_d[ins_idx]    = 1'b1;
                  evpn_d[ins_idx]  = vpn_q;
                  eppn_d[ins_idx]  = bus.drtol2_snack_ppn;
                  if (!free_found) rptr_d = rptr_q + 1'b1;
               end
               state_d = ACK;
            end
         end
         ACK: begin
            if (ack_valid_q && !bus.l2tlbtol1tlb_ack_retry) state_d = IDLE;
            else                                             ack_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rid_q        <= '0;
         vpn_q        <= '0;
         ppn_q        <= '0;
         fault_q      <= 1'b0;
         ack_valid_q  <= 1'b0;
         fill_valid_q <= 1'b0;
         l2id_q       <= L2ID_W'(1);
         out_id_q     <= '0;
         rptr_q       <= '0;
         hit_q        <= '0;
         miss_q       <= '0;
         ev_q         <= '0;
         evpn_q       <= '0;
         eppn_q       <= '0;
      end else begin
         state_q      <= state_d;
         rid_q        <= rid_d;
         vpn_q        <= vpn_d;
         ppn_q        <= ppn_d;
         fault_q      <= fault_d;
         ack_valid_q  <= ack_valid_d;
         fill_valid_q <= fill_valid_d;
         l2id_q       <= l2id_d;
         out_id_q     <= out_id_d;
         rptr_q       <= rptr_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         ev_q         <= ev_d;
         evpn_q       <= evpn_d;
         eppn_q       <= eppn_d;
      end
   end
endmodule

// File: tb/tb_l2tlb_fa.sv
// Directed plus randomized bench for l2tlb_fa against a slot-array translation model.
// Counters are narrowed so saturation is reachable in a short run.
module tb_l2tlb_fa;
   localparam int ENTRIES = 8;
   localparam int VPN_W   = 27;
   localparam int PPN_W   = 28;
   localparam int RID_W   = 3;
   localparam int L2ID_W  = 6;
   localparam int CNT_W   = 7;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int ID_MAX  = (1 << L2ID_W) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   l2tlb_fa_if #(.VPN_W(VPN_W), .PPN_W(PPN_W), .RID_W(RID_W), .L2ID_W(L2ID_W), .CNT_W(CNT_W)) bus ();

   l2tlb_fa #(.ENTRIES(ENTRIES), .VPN_W(VPN_W), .PPN_W(PPN_W), .RID_W(RID_W),
              .L2ID_W(L2ID_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [VPN_W-1:0] m_vpn [ENTRIES];
   logic [PPN_W-1:0] m_ppn [ENTRIES];
   bit               m_v   [ENTRIES];
   int               m_rptr, m_l2id, m_hits, m_misses;
   logic [VPN_W-1:0] pool  [12];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
      m_rptr = 0; m_l2id = 1; m_hits = 0; m_misses = 0;
   endfunction

   function automatic int m_find(input logic [VPN_W-1:0] v);
      for (int i = 0; i < ENTRIES; i++) if (m_v[i] && m_vpn[i] == v) return i;
      return -1;
   endfunction

   function automatic void m_install(input logic [VPN_W-1:0] v, input logic [PPN_W-1:0] p);
      int slot = -1;
      for (int i = 0; i < ENTRIES; i++) if (!m_v[i]) begin slot = i; break; end
      if (slot < 0) begin slot = m_rptr; m_rptr = (m_rptr + 1) % ENTRIES; end
      m_v[slot] = 1; m_vpn[slot] = v; m_ppn[slot] = p;
   endfunction

   task automatic xact(input logic [RID_W-1:0] rid, input logic [VPN_W-1:0] vpn,
                       input logic [PPN_W-1:0] fill_ppn, input bit fill_fault,
                       input bit stale, input int dr_stall, input int ack_stall);
      int n, idx, out_id, sid;
      bit saw_fill;
      logic [PPN_W-1:0] exp_ppn;
      bit exp_fault;
      idx = m_find(vpn);
      saw_fill = 0;
      @(negedge clk);
      bus.l1tlbtol2tlb_req_valid = 1; bus.l1tlbtol2tlb_req_rid = rid; bus.l1tlbtol2tlb_req_vpn = vpn;
      #1 chk("req_retry_idle", bus.l1tlbtol2tlb_req_retry, 0);
      @(posedge clk);
      @(negedge clk);
      bus.l1tlbtol2tlb_req_valid = 0;
      #1 chk("req_retry_busy", bus.l1tlbtol2tlb_req_retry, 1);
      if (idx >= 0) begin
         if (m_hits < CNT_MAX) m_hits++;
         exp_ppn = m_ppn[idx]; exp_fault = 0;
         n = 0;
         while (!bus.l2tlbtol1tlb_ack_valid && n < 20) begin
            if (bus.l2todr_req_valid) saw_fill = 1;
            @(negedge clk); n++;
         end
         chk("hit_latency", n, 2);
         chk("hit_no_fill", saw_fill, 0);
      end else begin
         if (m_misses < CNT_MAX) m_misses++;
         n = 0;
         while (!bus.l2todr_req_valid && n < 20) begin @(negedge clk); n++; end
         chk("fill_latency", n, 2);
         chk("fill_l2id", bus.l2todr_req_l2id, m_l2id);
         chk("fill_vpn", bus.l2todr_req_vpn, vpn);
         bus.l2todr_req_retry = (dr_stall > 0);
         repeat (dr_stall) begin
            @(negedge clk);
            chk("fill_hold_valid", bus.l2todr_req_valid, 1);
            chk("fill_hold_l2id", bus.l2todr_req_l2id, m_l2id);
         end
         bus.l2todr_req_retry = 0;
         @(posedge clk);
         out_id = m_l2id;
         m_l2id = (m_l2id == ID_MAX) ? 1 : m_l2id + 1;
         @(negedge clk);
         chk("fill_drop", bus.l2todr_req_valid, 0);
         chk("snack_retry_wait", bus.drtol2_snack_retry, 0);
         if (stale) begin
            sid = (out_id == 7) ? 8 : 7;
            bus.drtol2_snack_valid = 1; bus.drtol2_snack_l2id = sid[L2ID_W-1:0];
            bus.drtol2_snack_ppn = 28'h0BAD; bus.drtol2_snack_fault = 0;
            @(posedge clk);
            @(negedge clk);
            bus.drtol2_snack_valid = 0;
            #1 chk("stale_snack_retry", bus.drtol2_snack_retry, 0);
            chk("stale_no_ack", bus.l2tlbtol1tlb_ack_valid, 0);
         end
         bus.drtol2_snack_valid = 1; bus.drtol2_snack_l2id = out_id[L2ID_W-1:0];
         bus.drtol2_snack_ppn = fill_ppn; bus.drtol2_snack_fault = fill_fault;
         @(posedge clk);
         @(negedge clk);
         bus.drtol2_snack_valid = 0;
         #1 chk("ack_not_yet", bus.l2tlbtol1tlb_ack_valid, 0);
         chk("snack_retry_ack", bus.drtol2_snack_retry, 1);
         @(negedge clk);
         exp_fault = fill_fault;
         exp_ppn   = fill_fault ? '0 : fill_ppn;
         if (!fill_fault) m_install(vpn, fill_ppn);
      end
      chk("ack_valid", bus.l2tlbtol1tlb_ack_valid, 1);
      chk("ack_rid", bus.l2tlbtol1tlb_ack_rid, rid);
      chk("ack_ppn", bus.l2tlbtol1tlb_ack_ppn, exp_ppn);
      chk("ack_fault", bus.l2tlbtol1tlb_ack_fault, exp_fault);
      bus.l2tlbtol1tlb_ack_retry = (ack_stall > 0);
      repeat (ack_stall) begin
         @(negedge clk);
         chk("ack_hold_valid", bus.l2tlbtol1tlb_ack_valid, 1);
         chk("ack_hold_ppn", bus.l2tlbtol1tlb_ack_ppn, exp_ppn);
         chk("ack_hold_rid", bus.l2tlbtol1tlb_ack_rid, rid);
         chk("ack_hold_flush_retry", bus.flush_retry, 1);
      end
      bus.l2tlbtol1tlb_ack_retry = 0;
      @(posedge clk);
      @(negedge clk);
      chk("ack_drop", bus.l2tlbtol1tlb_ack_valid, 0);
      chk("hit_count", bus.hit_count, m_hits);
      chk("miss_count", bus.miss_count, m_misses);
   endtask

   task automatic flush_with_req(input logic [VPN_W-1:0] vpn);
      @(negedge clk);
      bus.flush_valid = 1; bus.l1tlbtol2tlb_req_valid = 1;
      bus.l1tlbtol2tlb_req_rid = 3'd1; bus.l1tlbtol2tlb_req_vpn = vpn;
      #1 chk("flush_retry_idle", bus.flush_retry, 0);
      chk("req_retry_flush", bus.l1tlbtol2tlb_req_retry, 1);
      @(posedge clk);
      @(negedge clk);
      bus.flush_valid = 0; bus.l1tlbtol2tlb_req_valid = 0;
      for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
      #1 chk("flush_still_idle", bus.l1tlbtol2tlb_req_retry, 0);
   endtask

   task automatic mid_fill_reset(input logic [VPN_W-1:0] vpn);
      int n;
      @(negedge clk);
      bus.l1tlbtol2tlb_req_valid = 1; bus.l1tlbtol2tlb_req_rid = 3'd3; bus.l1tlbtol2tlb_req_vpn = vpn;
      @(posedge clk);
      @(negedge clk);
      bus.l1tlbtol2tlb_req_valid = 0;
      n = 0;
      while (!bus.l2todr_req_valid && n < 20) begin @(negedge clk); n++; end
      chk("mfr_fill_valid", bus.l2todr_req_valid, 1);
      @(posedge clk);
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      m_reset();
      bus.drtol2_snack_valid = 1; bus.drtol2_snack_l2id = m_l2id[L2ID_W-1:0];
      bus.drtol2_snack_ppn = 28'h777; bus.drtol2_snack_fault = 0;
      repeat (3) begin
         #1 chk("mfr_snack_held", bus.drtol2_snack_retry, 1);
         chk("mfr_no_ack", bus.l2tlbtol1tlb_ack_valid, 0);
         @(negedge clk);
      end
      bus.drtol2_snack_valid = 0;
      chk("mfr_hits", bus.hit_count, 0);
      chk("mfr_misses", bus.miss_count, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.l1tlbtol2tlb_req_valid = 0; bus.l1tlbtol2tlb_req_rid = '0; bus.l1tlbtol2tlb_req_vpn = '0;
      bus.l2tlbtol1tlb_ack_retry = 0; bus.l2todr_req_retry = 0;
      bus.drtol2_snack_valid = 0; bus.drtol2_snack_l2id = '0; bus.drtol2_snack_ppn = '0;
      bus.drtol2_snack_fault = 0; bus.flush_valid = 0;
      reset = 1;
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 0;
      #1;
      chk("rst_ack_valid", bus.l2tlbtol1tlb_ack_valid, 0);
      chk("rst_ack_payload", {bus.l2tlbtol1tlb_ack_rid, bus.l2tlbtol1tlb_ack_ppn, bus.l2tlbtol1tlb_ack_fault}, 0);
      chk("rst_fill_valid", bus.l2todr_req_valid, 0);
      chk("rst_fill_payload", {bus.l2todr_req_l2id, bus.l2todr_req_vpn}, 0);
      chk("rst_counts", {bus.hit_count, bus.miss_count}, 0);
      chk("rst_req_retry", bus.l1tlbtol2tlb_req_retry, 0);
      chk("rst_flush_retry", bus.flush_retry, 0);
      chk("rst_snack_retry", bus.drtol2_snack_retry, 1);

      xact(3'd2, 27'h100, 28'h55, 0, 0, 0, 0);
      xact(3'd5, 27'h100, 28'h0, 0, 0, 0, 0);
      for (int i = 2; i <= 9; i++) xact(3'(i), 27'(i * 'h100), 28'(i * 'h11), 0, 0, i % 3, 0);
      xact(3'd1, 27'h200, 28'h0, 0, 0, 0, 0);
      xact(3'd1, 27'h100, 28'h66, 0, 0, 0, 0);
      xact(3'd4, 27'hABC, 28'h1234, 0, 1, 1, 0);
      xact(3'd6, 27'hDEF, 28'h9999, 1, 0, 0, 0);
      xact(3'd6, 27'hDEF, 28'h4321, 0, 0, 0, 0);
      flush_with_req(27'h300);
      xact(3'd7, 27'hABC, 28'h2222, 0, 0, 0, 3);
      mid_fill_reset(27'h5000);

      xact(3'd0, 27'h42, 28'hC0FFEE, 0, 0, 0, 0);
      for (int i = 0; i < CNT_MAX + 5; i++) xact(3'(i), 27'h42, 28'h0, 0, 0, 0, 0);
      chk("hit_saturated", bus.hit_count, CNT_MAX);

      for (int i = 0; i < 12; i++) pool[i] = 27'($urandom);
      for (int it = 0; it < 400; it++) begin
         xact(3'($urandom_range(0, 7)), pool[$urandom_range(0, 11)], 28'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
